// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg: shared widths and snapshot field layout for the counter monitor
package count_monitor_pkg;
  localparam int CNT_W_DEF = 4;
  localparam int EPOCH_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int SNAP_CNT_LSB = 0;
endpackage

// File: rtl/count_monitor_if.sv
// count_monitor_if: valid/ready snapshot readout channel
interface count_monitor_if #(parameter int W = 12);
  logic snap_valid;
  logic snap_ready;
  logic [W-1:0] snap_data;
  modport master(output snap_valid, output snap_data, input snap_ready);
  modport slave(input snap_valid, input snap_data, output snap_ready);
endinterface

// File: rtl/count_monitor_snap_fifo.sv
// snap_fifo: register-array FIFO with separate level count, no empty bypass
module snap_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] lvl_q;
  logic do_push, do_pop;
  assign empty = lvl_q == '0;
  assign full = lvl_q == (AW+1)'(DEPTH);
  assign do_pop = pop & ~clr & ~empty;
  assign do_push = push & ~clr & (~full | do_pop);
  assign level = lvl_q;
  assign dout = empty ? '0 : mem_q[rd_q];
  // pointers and occupancy; clr flushes, pointers wrap modulo DEPTH
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // entry storage; stale contents are masked by the empty gate on dout
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/count_monitor.sv
// count_monitor: epoch tally of counter wraps with timestamped snapshot FIFO
module count_monitor
  import count_monitor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EPOCH_W = EPOCH_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic [CNT_W-1:0]         c_in,
  input  logic                     ovf_in,
  input  logic                     cap_req,
  count_monitor_if.master          snap,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     epoch_sat,
  output logic                     drop_flag
);
  logic ovf_q;
  logic [EPOCH_W-1:0] epoch_q, epoch_d, epoch_inc;
  logic sat_q, sat_d, drop_q, drop_d;
  logic ovf_rise, full, empty;
  logic [EPOCH_W+CNT_W-1:0] snap_din;
  assign ovf_rise = ovf_in & ~ovf_q;
  assign epoch_inc = epoch_q + 1'b1;
  // next epoch saturates at all-ones; flags are sticky until CLR
  always_comb begin
    epoch_d = CLR ? '0 : (ovf_rise && !(&epoch_q)) ? epoch_inc : epoch_q;
    sat_d = CLR ? 1'b0 : sat_q | (ovf_rise & (&epoch_inc));
    drop_d = CLR ? 1'b0 : drop_q | (cap_req & full & ~snap.snap_ready);
    snap_din = '0;
    snap_din[SNAP_CNT_LSB +: CNT_W] = c_in;
    snap_din[SNAP_CNT_LSB+CNT_W +: EPOCH_W] = epoch_q;
  end
  // edge-detect history keeps sampling through CLR so a held level is not re-counted
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
      epoch_q <= '0;
      sat_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ovf_q <= ovf_in;
      epoch_q <= epoch_d;
      sat_q <= sat_d;
      drop_q <= drop_d;
    end
  end
  snap_fifo #(.W(EPOCH_W+CNT_W), .DEPTH(DEPTH)) u_fifo (
    .CLK(CLK), .RST(RST), .clr(CLR), .push(cap_req), .pop(snap.snap_ready),
    .din(snap_din), .dout(snap.snap_data), .level(fifo_level), .full(full), .empty(empty)
  );
  assign snap.snap_valid = ~empty;
  assign epoch_sat = sat_q;
  assign drop_flag = drop_q;
endmodule
